weather_feature_extractor: RTL and testbench

- Producer side of the weather classifier's feature interface.
- Consumes a stream of raw sensor samples over one observation day.
- On a day-end strobe, reduces the day to four 4-bit quantized features: max temp, min temp, total precipitation and peak wind.
- Presents the features to the classifier through a valid/ready handshake, with a one-entry output buffer so the next day's accumulation continues while a result waits.

---
 rtl/weather_pkg.sv | 18 +
 rtl/weather_quantizer.sv | 21 ++
 rtl/weather_feature_extractor.sv | 142 ++++++++++++++
 tb/tb_weather_feature_extractor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/weather_pkg.sv
// Shared types and widths for the weather feature interface; the classifier
// imports feat_t from here as well.
package weather_pkg;
  localparam int FEAT_W   = 4;
  localparam int SAMPLE_W = 8;
  localparam int PSUM_W   = 12;
  // signed width wide enough for a saturated psum and for any temp - TEMP_BASE
  localparam int Q_W      = 14;

  typedef enum logic {IDLE_BUF = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [FEAT_W-1:0] temp_max;
    logic [FEAT_W-1:0] temp_min;
    logic [FEAT_W-1:0] precip;
    logic [FEAT_W-1:0] wind;
  } feat_t;
endpackage

// File: rtl/weather_quantizer.sv
// Per-feature quantizer: negative input maps to 0, otherwise x>>SHIFT clamped
// to the largest feature code.
module weather_quantizer
  import weather_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic signed [Q_W-1:0]    x,
  output logic        [FEAT_W-1:0] q
);
  localparam logic signed [Q_W-1:0] QMAX = Q_W'((1 << FEAT_W) - 1);

  logic signed [Q_W-1:0] sh;

  always_comb begin
    sh = x >>> SHIFT;
    if (x[Q_W-1])     q = '0;
    else if (sh > QMAX) q = '1;
    else              q = sh[FEAT_W-1:0];
  end
endmodule

// File: rtl/weather_feature_extractor.sv
// Daily weather feature extractor with a one-entry valid/ready output buffer.
// Optional macro WEATHER_FEATURE_OVERRUN_CNT_EN adds a dropped-day counter port.
module weather_feature_extractor
  import weather_pkg::*;
#(
  parameter int TEMP_BASE    = -10,
  parameter int TEMP_SHIFT   = 2,
  parameter int PRECIP_SHIFT = 2,
  parameter int WIND_SHIFT   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_temp,
  input  logic        [SAMPLE_W-1:0] sample_precip,
  input  logic        [SAMPLE_W-1:0] sample_wind,
  input  logic                       day_end,
  output logic                       feat_valid,
  input  logic                       feat_ready,
  output logic        [FEAT_W-1:0]   out_temp_max,
  output logic        [FEAT_W-1:0]   out_temp_min,
  output logic        [FEAT_W-1:0]   out_precipitation,
  output logic        [FEAT_W-1:0]   out_wind,
`ifdef WEATHER_FEATURE_OVERRUN_CNT_EN
  output logic        [7:0]          overrun_cnt,
`endif
  output logic                       overrun,
  output logic                       empty_day
);
  logic signed [SAMPLE_W-1:0] tmax, tmin, t_hi, t_lo;
  logic        [PSUM_W-1:0]   psum, p_nx;
  logic        [PSUM_W:0]     p_add;
  logic        [SAMPLE_W-1:0] wmax, w_nx, cnt, c_nx;
  logic                       close, load, drop;
  state_t                     state, state_nx;
  feat_t                      feat_q, feat_nx;
  logic signed [Q_W-1:0]      x_hi, x_lo, x_p, x_w;

  // Accumulators merged with this cycle's sample, so a sample coincident
  // with day_end lands in the closing day.
  always_comb begin
    t_hi = tmax;
    t_lo = tmin;
    p_nx = psum;
    w_nx = wmax;
    c_nx = cnt;
    p_add = {1'b0, psum} + {{(PSUM_W+1-SAMPLE_W){1'b0}}, sample_precip};
    if (sample_valid) begin
      if (sample_temp > tmax) t_hi = sample_temp;
      if (sample_temp < tmin) t_lo = sample_temp;
      p_nx = p_add[PSUM_W] ? '1 : p_add[PSUM_W-1:0];
      if (sample_wind > wmax) w_nx = sample_wind;
      if (cnt != '1) c_nx = cnt + 1'b1;
    end
  end

  assign close = day_end && (sample_valid || cnt != '0);

  assign x_hi = Q_W'(t_hi) - Q_W'(TEMP_BASE);
  assign x_lo = Q_W'(t_lo) - Q_W'(TEMP_BASE);
  assign x_p  = Q_W'(p_nx);
  assign x_w  = Q_W'(w_nx);

  weather_quantizer #(.SHIFT(TEMP_SHIFT))   u_q_tmax (.x(x_hi), .q(feat_nx.temp_max));
  weather_quantizer #(.SHIFT(TEMP_SHIFT))   u_q_tmin (.x(x_lo), .q(feat_nx.temp_min));
  weather_quantizer #(.SHIFT(PRECIP_SHIFT)) u_q_prec (.x(x_p),  .q(feat_nx.precip));
  weather_quantizer #(.SHIFT(WIND_SHIFT))   u_q_wind (.x(x_w),  .q(feat_nx.wind));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmax <= -8'sd128;
      tmin <= 8'sd127;
      psum <= '0;
      wmax <= '0;
      cnt  <= '0;
    end else if (close) begin
      tmax <= -8'sd128;
      tmin <= 8'sd127;
      psum <= '0;
      wmax <= '0;
      cnt  <= '0;
    end else if (sample_valid) begin
      tmax <= t_hi;
      tmin <= t_lo;
      psum <= p_nx;
      wmax <= w_nx;
      cnt  <= c_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE_BUF;
    else        state <= state_nx;
  end

  // HOLD always presents valid, so feat_ready alone is the handshake there.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    drop     = 1'b0;
    case (state)
      IDLE_BUF: if (close) begin
        load     = 1'b1;
        state_nx = HOLD;
      end
      HOLD: begin
        if (feat_ready) begin
          if (close) load = 1'b1;
          else       state_nx = IDLE_BUF;
        end else if (close) begin
          drop = 1'b1;
        end
      end
      default: state_nx = IDLE_BUF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_q    <= '0;
      overrun   <= 1'b0;
      empty_day <= 1'b0;
    end else begin
      if (load) feat_q <= feat_nx;
      if (drop) overrun <= 1'b1;
      empty_day <= day_end && !sample_valid && cnt == '0;
    end
  end

`ifdef WEATHER_FEATURE_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     overrun_cnt <= '0;
    else if (drop && overrun_cnt != '1) overrun_cnt <= overrun_cnt + 1'b1;
  end
`endif

  assign feat_valid        = (state == HOLD);
  assign out_temp_max      = feat_q.temp_max;
  assign out_temp_min      = feat_q.temp_min;
  assign out_precipitation = feat_q.precip;
  assign out_wind          = feat_q.wind;
endmodule

// File: tb/tb_weather_feature_extractor.sv
// Bench for weather_feature_extractor: table of single-sample days plus
// hand-written multi-cycle sequences, checked through an expected-feature queue.
module tb_weather_feature_extractor;
  import weather_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_valid, day_end, feat_ready;
  logic [7:0] sample_temp, sample_precip, sample_wind;
  logic       feat_valid, overrun, empty_day;
  logic [3:0] out_temp_max, out_temp_min, out_precipitation, out_wind;
`ifdef WEATHER_FEATURE_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  int    n_cmp = 0;
  int    n_bad = 0;
  feat_t exp_q[$];

  typedef struct {
    int temp, precip, wind;
    int e_tmax, e_tmin, e_prec, e_wind;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  weather_feature_extractor dut (
    .clk(clk), .rst_n(rst_n),
    .sample_valid(sample_valid), .sample_temp(sample_temp),
    .sample_precip(sample_precip), .sample_wind(sample_wind),
    .day_end(day_end), .feat_valid(feat_valid), .feat_ready(feat_ready),
    .out_temp_max(out_temp_max), .out_temp_min(out_temp_min),
    .out_precipitation(out_precipitation), .out_wind(out_wind),
`ifdef WEATHER_FEATURE_OVERRUN_CNT_EN
    .overrun_cnt(overrun_cnt),
`endif
    .overrun(overrun), .empty_day(empty_day)
  );

  function automatic feat_t mk(int a, int b, int c, int d);
    feat_t f;
    f.temp_max = a[3:0];
    f.temp_min = b[3:0];
    f.precip   = c[3:0];
    f.wind     = d[3:0];
    return f;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(bit v, int t, int p, int w, bit de);
    sample_valid  = v;
    sample_temp   = t[7:0];
    sample_precip = p[7:0];
    sample_wind   = w[7:0];
    day_end       = de;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    day_end      = 1'b0;
  endtask

  // Scoreboard: every accepted feature set must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && feat_valid === 1'b1 && feat_ready === 1'b1) begin
      feat_t got, exp;
      got = {out_temp_max, out_temp_min, out_precipitation, out_wind};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL accept_unexpected: got %h expected none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_bad++;
          $display("FAIL accept_features: got %h expected %h", got, exp);
        end
      end
    end
  end

  initial begin
    tbl[0] = '{20,   3,   7,  7,  7,  0,  3};
    tbl[1] = '{-10,  0,   0,  0,  0,  0,  0};
    tbl[2] = '{-128, 255, 255, 0, 0, 15, 15};
    tbl[3] = '{127,  40,  30, 15, 15, 10, 15};
    tbl[4] = '{-7,   8,   1,  0,  0,  2,  0};
    tbl[5] = '{49,   63,  31, 14, 14, 15, 15};
    tbl[6] = '{2,    7,   4,  3,  3,  1,  2};

    rst_n = 1'b0; sample_valid = 0; day_end = 0; feat_ready = 0;
    sample_temp = 0; sample_precip = 0; sample_wind = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_feat_valid", feat_valid, 0);
    chk("rst_outs", {out_temp_max, out_temp_min, out_precipitation, out_wind}, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_empty_day", empty_day, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three-sample day, then a separate day_end.
    feat_ready = 1'b1;
    cyc(1, 20, 3, 7, 0);
    cyc(1, 5, 4, 22, 0);
    cyc(1, 12, 6, 9, 0);
    exp_q.push_back(mk(7, 3, 3, 11));
    cyc(0, 0, 0, 0, 1);
    chk("d1_valid", feat_valid, 1);
    cyc(0, 0, 0, 0, 0);
    chk("d1_valid_drop", feat_valid, 0);

    // Clamp high, clamp low, precipitation saturation.
    exp_q.push_back(mk(15, 15, 0, 0));
    cyc(1, 70, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      if (i == 29) exp_q.push_back(mk(0, 0, 15, 0));
      cyc(1, -20, 200, 0, i == 29);
    end
    cyc(0, 0, 0, 0, 0);
    chk("sat_drained", exp_q.size(), 0);

    // Empty day.
    cyc(0, 0, 0, 0, 1);
    chk("empty_pulse", empty_day, 1);
    chk("empty_no_valid", feat_valid, 0);
    cyc(0, 0, 0, 0, 0);
    chk("empty_pulse_end", empty_day, 0);
    chk("empty_no_overrun", overrun, 0);

    // Back-to-back reload in HOLD with ready in the same cycle.
    feat_ready = 1'b0;
    exp_q.push_back(mk(7, 7, 0, 3));
    cyc(1, 20, 3, 7, 1);
    cyc(0, 0, 0, 0, 0);
    chk("b2b_hold", feat_valid, 1);
    feat_ready = 1'b1;
    exp_q.push_back(mk(15, 15, 10, 15));
    cyc(1, 127, 40, 30, 1);
    chk("b2b_valid", feat_valid, 1);
    chk("b2b_tmax", out_temp_max, 15);
    chk("b2b_no_overrun", overrun, 0);
    cyc(0, 0, 0, 0, 0);
    chk("b2b_done", feat_valid, 0);

    // Table of single-sample days with coincident day_end.
    foreach (tbl[k]) begin
      exp_q.push_back(mk(tbl[k].e_tmax, tbl[k].e_tmin, tbl[k].e_prec, tbl[k].e_wind));
      cyc(1, tbl[k].temp, tbl[k].precip, tbl[k].wind, 1);
      chk($sformatf("tbl%0d_valid", k), feat_valid, 1);
      cyc(0, 0, 0, 0, 0);
      chk($sformatf("tbl%0d_drop", k), feat_valid, 0);
    end

    // Overrun: day B closes while day A waits unaccepted.
    feat_ready = 1'b0;
    exp_q.push_back(mk(7, 7, 0, 3));
    cyc(1, 20, 3, 7, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, -10, 0, 0, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", feat_valid, 1);
    chk("ovr_hold_outs", {out_temp_max, out_temp_min, out_precipitation, out_wind}, 16'h7703);
`ifdef WEATHER_FEATURE_OVERRUN_CNT_EN
    chk("ovr_cnt", overrun_cnt, 1);
`endif
    cyc(0, 0, 0, 0, 0);
    chk("ovr_sticky", overrun, 1);
    feat_ready = 1'b1;
    cyc(0, 0, 0, 0, 0);
    chk("ovr_released", feat_valid, 0);

    // Reset mid-day: pre-reset samples must not leak into the next day.
    cyc(1, 127, 255, 255, 0);
    cyc(1, 127, 255, 255, 0);
    cyc(1, 127, 255, 255, 0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_valid", feat_valid, 0);
    exp_q.delete();
    rst_n = 1'b1;
    exp_q.push_back(mk(10, 10, 0, 0));
    cyc(1, 30, 0, 0, 1);
    chk("post_rst_tmax", out_temp_max, 10);
    chk("post_rst_tmin", out_temp_min, 10);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("final_drain", exp_q.size(), 0);
    #1;
    chk("final_idle", feat_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
